core_issue_ctrl: RTL and testbench
==================================

Name: core_issue_ctrl

Overview:
- Issue/hazard controller for the core front end.
- Sits beside the decode stage and drives that stage's stall and flush inputs.
- Keeps a per-register scoreboard of pending writebacks and sequences multi-cycle MUL and load/store occupancy.
- Converts execute-stage redirects into decode flushes.

Parameters:
- REG_BITS, 4: width of a register index; register 0 is R0, which is hardwired and never pending.
- MUL_CYCLES, 3: execute occupancy of a MUL in cycles, ≥1.

Ports:
- clk  in  1  core clock
- rst  in  1  asynchronous reset, active-high
- dec_execute  in  1  decoded instruction is executable (not NOP/bubble)
- dec_uses_ra  in  1  reads ra
- dec_uses_rb  in  1  reads rb
- dec_writeback  in  1  writes rd
- dec_ra, dec_rb, dec_rd  in  REG_BITS  register indices
- dec_mul  in  1  instruction is MUL
- dec_ldst  in  1  instruction is a load/store
- ex_redirect  in  1  taken branch resolved in execute this cycle
- mem_ack  in  1  memory completed the outstanding load/store
- wb_valid  in  1  register write committing this cycle
- wb_rd  in  REG_BITS  register being written
- stall  out  1  hold decode register
- flush  out  1  squash decode register
- issue  out  1  pulse: instruction leaves decode this cycle
- busy  out  1  FSM not in RUN

Behaviour:
- Reset (rst high, async):
  - state=RUN, scoreboard all 0, mul counter 0.
  - All outputs 0 while rst is high.
- Scoreboard: one pending bit per register; bit 0 is forced 0.
- Set/clear rules:
  - Set rd on issue with dec_writeback=1 and rd≠0.
  - Clear wb_rd on wb_valid.
  - Set and clear of the same register in one cycle: set wins.
- hazard (combinational) = (dec_uses_ra & pend[ra]) | (dec_uses_rb & pend[rb]) | (dec_writeback & pend[rd]).
  - The rd term enforces WAW ordering.
- Outputs:
  - flush = ex_redirect (combinational, same cycle).
  - stall = !flush & dec_execute & (hazard | state≠RUN).
  - issue = dec_execute & !stall & !flush & state==RUN.
  - A non-executable decode slot never stalls.
- FSM, next-state priority top to bottom:
  - RUN:
    - issue & dec_mul & MUL_CYCLES>1 → MULWAIT, counter=MUL_CYCLES-1.
    - issue & dec_ldst → MEMWAIT.
    - Otherwise stay in RUN.
  - MULWAIT: counter decrements each cycle; counter==1 → RUN. Exactly MUL_CYCLES-1 stall cycles follow a MUL issue.
  - MEMWAIT: stay until mem_ack; mem_ack → RUN in the next cycle. The same-cycle mem_ack does not release the stall.
  - mem_ack while in RUN or MULWAIT is ignored.
- ex_redirect:
  - Does not alter FSM state or the counter. Older MUL and memory ops still complete.
  - Does not clear the scoreboard, because pending writes belong to older instructions.
  - The instruction in decode is squashed, not issued.
- Counter width is clog2(MUL_CYCLES)+1; the counter never wraps, and saturates at 0 in RUN.
- Reset asserted mid-MULWAIT/MEMWAIT returns to RUN immediately, with no pending state kept.

Optional Feature:
- Macro: CORE_ISSUE_BYPASS_EN.
- When defined:
  - A source operand whose pending bit matches wb_rd with wb_valid=1 in the same cycle is treated as not pending, so it issues that cycle.
  - The rd (WAW) term is also relieved.
- When undefined:
  - The scoreboard bit must already be clear (registered), which costs one extra stall cycle after writeback.

Test Plan:
- Reset: rst=1 mid-MULWAIT → stall=flush=issue=busy=0 immediately; after release, a RUN-state ADD r1 issues in cycle 0.
- RAW: issue ADD rd=r3, next insn uses_ra r3 → stall=1 until wb_valid/wb_rd=3.
  - Without bypass: issue one cycle after wb.
  - With CORE_ISSUE_BYPASS_EN: issue in the wb cycle.
- MUL: MUL_CYCLES=3, issue MUL r2 → busy=1 and stall=1 for exactly 2 cycles on any dec_execute, then RUN.
- Load: issue LD r5; mem_ack asserted 4 cycles later → stall through the ack cycle, issue on the following cycle; scoreboard r5 stays set until wb_rd=5.
- Redirect: ex_redirect=1 while dependent insn stalled in MEMWAIT → flush=1, stall=0, issue=0; state remains MEMWAIT until mem_ack.
- R0/collision: insn writing r0 sets nothing; wb_valid wb_rd=4 in the same cycle as a new issue with rd=4 → pend[4] remains 1.

Source files
------------

// File: rtl/core_issue_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : core_issue_ctrl_if
// Description : Bundle between the decode stage / pipeline (master) and the
//               issue/hazard controller (slave).
//               Decode-side inputs : dec_execute, dec_uses_ra, dec_uses_rb,
//                                    dec_writeback, dec_ra, dec_rb, dec_rd,
//                                    dec_mul, dec_ldst
//               Pipeline inputs    : ex_redirect, mem_ack, wb_valid, wb_rd
//               Controller outputs : stall, flush, issue, busy
// Revision    : 1.0 - initial release
// ============================================================================
interface core_issue_ctrl_if #(
  parameter int REG_BITS = 4
);
  logic                dec_execute;
  logic                dec_uses_ra;
  logic                dec_uses_rb;
  logic                dec_writeback;
  logic [REG_BITS-1:0] dec_ra;
  logic [REG_BITS-1:0] dec_rb;
  logic [REG_BITS-1:0] dec_rd;
  logic                dec_mul;
  logic                dec_ldst;
  logic                ex_redirect;
  logic                mem_ack;
  logic                wb_valid;
  logic [REG_BITS-1:0] wb_rd;
  logic                stall;
  logic                flush;
  logic                issue;
  logic                busy;

  modport master (
    output dec_execute, dec_uses_ra, dec_uses_rb, dec_writeback,
           dec_ra, dec_rb, dec_rd, dec_mul, dec_ldst,
           ex_redirect, mem_ack, wb_valid, wb_rd,
    input  stall, flush, issue, busy
  );

  modport slave (
    input  dec_execute, dec_uses_ra, dec_uses_rb, dec_writeback,
           dec_ra, dec_rb, dec_rd, dec_mul, dec_ldst,
           ex_redirect, mem_ack, wb_valid, wb_rd,
    output stall, flush, issue, busy
  );
endinterface
`default_nettype wire

// File: rtl/core_issue_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : core_issue_ctrl
// Description : Issue/hazard controller beside the decode stage. Keeps a
//               per-register scoreboard of pending writebacks, sequences
//               multi-cycle MUL and load/store occupancy, and turns execute
//               redirects into decode flushes.
//               Ports : clk, rst (async, active-high)
//                       ctrl_if (core_issue_ctrl_if.slave) - decode fields,
//                       redirect/mem_ack/writeback inputs and the
//                       stall/flush/issue/busy outputs.
//               Option: define CORE_ISSUE_BYPASS_EN to let a same-cycle
//                       writeback release a pending operand/destination.
// Revision    : 1.0 - initial release
// ============================================================================
module core_issue_ctrl #(
  parameter int REG_BITS   = 4,
  parameter int MUL_CYCLES = 3
) (
  input  logic                clk,
  input  logic                rst,
  core_issue_ctrl_if.slave    ctrl_if
);

  localparam int NREG = 1 << REG_BITS;
  localparam int CW   = $clog2(MUL_CYCLES) + 1;
  localparam logic [CW-1:0] C_MUL_LOAD = CW'(MUL_CYCLES - 1);
  localparam logic [CW-1:0] C_CNT_ONE  = CW'(1);

  localparam logic [1:0] ST_RUN     = 2'd0;
  localparam logic [1:0] ST_MULWAIT = 2'd1;
  localparam logic [1:0] ST_MEMWAIT = 2'd2;

  logic [1:0]      state_q, state_d;
  logic [CW-1:0]   cnt_q,   cnt_d;
  logic [NREG-1:0] pend_q,  pend_d;

  logic [NREG-1:0] w_wb_mask;
  logic [NREG-1:0] w_set_mask;
  logic [NREG-1:0] w_pend_eff;
  logic            w_hazard;
  logic            w_run;
  logic            w_flush;
  logic            w_stall;
  logic            w_issue;

  assign w_wb_mask = ctrl_if.wb_valid ? (NREG'(1) << ctrl_if.wb_rd) : '0;

`ifdef CORE_ISSUE_BYPASS_EN
  // A register committing this cycle is already safe to read or overwrite.
  assign w_pend_eff = pend_q & ~w_wb_mask;
`else
  assign w_pend_eff = pend_q;
`endif

  assign w_hazard = (ctrl_if.dec_uses_ra   & w_pend_eff[ctrl_if.dec_ra]) |
                    (ctrl_if.dec_uses_rb   & w_pend_eff[ctrl_if.dec_rb]) |
                    (ctrl_if.dec_writeback & w_pend_eff[ctrl_if.dec_rd]);

  assign w_run   = (state_q == ST_RUN);
  // Outputs are forced low while reset is held, independent of the inputs.
  assign w_flush = ctrl_if.ex_redirect & ~rst;
  assign w_stall = ~w_flush & ctrl_if.dec_execute & (w_hazard | ~w_run) & ~rst;
  assign w_issue = ctrl_if.dec_execute & ~w_stall & ~w_flush & w_run & ~rst;

  assign ctrl_if.flush = w_flush;
  assign ctrl_if.stall = w_stall;
  assign ctrl_if.issue = w_issue;
  assign ctrl_if.busy  = ~w_run & ~rst;

  // Set of a new destination takes priority over a same-cycle writeback clear.
  assign w_set_mask = (w_issue & ctrl_if.dec_writeback) ?
                      (NREG'(1) << ctrl_if.dec_rd) : '0;

  always_comb begin
    pend_d    = (pend_q & ~w_wb_mask) | w_set_mask;
    pend_d[0] = 1'b0;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_RUN: begin
        if (w_issue && ctrl_if.dec_mul && (MUL_CYCLES > 1)) begin
          state_d = ST_MULWAIT;
          cnt_d   = C_MUL_LOAD;
        end else if (w_issue && ctrl_if.dec_ldst) begin
          state_d = ST_MEMWAIT;
        end
      end
      ST_MULWAIT: begin
        if (cnt_q == C_CNT_ONE) begin
          state_d = ST_RUN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - C_CNT_ONE;
        end
      end
      ST_MEMWAIT: begin
        // The ack cycle itself still stalls; decode is released next cycle.
        if (ctrl_if.mem_ack) begin
          state_d = ST_RUN;
        end
      end
      default: begin
        state_d = ST_RUN;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_RUN;
      cnt_q   <= '0;
      pend_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pend_q  <= pend_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_core_issue_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_core_issue_ctrl
// Description : Self-checking bench for core_issue_ctrl. Directed scenarios
//               followed by random traffic, each cycle compared against a
//               behavioural model holding pending registers, remaining MUL
//               stall cycles and an outstanding-memory flag.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_core_issue_ctrl;

  localparam int RB = 4;
  localparam int MC = 3;
  localparam int NR = 1 << RB;
`ifdef CORE_ISSUE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  core_issue_ctrl_if #(.REG_BITS(RB)) bus ();

  core_issue_ctrl #(.REG_BITS(RB), .MUL_CYCLES(MC)) dut (
    .clk     (clk),
    .rst     (rst),
    .ctrl_if (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state
  bit m_pend [NR];
  int m_mul_left;
  bit m_mem_wait;

  task automatic model_reset();
    for (int i = 0; i < NR; i++) m_pend[i] = 1'b0;
    m_mul_left = 0;
    m_mem_wait = 1'b0;
  endtask

  task automatic chk(string tag, logic obs, logic exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %b expected %b", tag, obs, exp);
    end
  endtask

  function automatic bit pend_now(int r);
    if (r == 0) return 1'b0;
    if (BYP && bus.wb_valid && int'(bus.wb_rd) == r) return 1'b0;
    return m_pend[r];
  endfunction

  // Checks outputs for the currently driven inputs, then advances one clock.
  task automatic cyc(string tag);
    bit hz, bz, fl, st, is;
    #2;
    bz = (m_mul_left > 0) || m_mem_wait;
    hz = (bus.dec_uses_ra   && pend_now(int'(bus.dec_ra))) ||
         (bus.dec_uses_rb   && pend_now(int'(bus.dec_rb))) ||
         (bus.dec_writeback && pend_now(int'(bus.dec_rd)));
    fl = bus.ex_redirect;
    st = !fl && bus.dec_execute && (hz || bz);
    is = bus.dec_execute && !st && !fl && !bz;
    chk({tag, ".flush"}, bus.flush, fl);
    chk({tag, ".stall"}, bus.stall, st);
    chk({tag, ".issue"}, bus.issue, is);
    chk({tag, ".busy"},  bus.busy,  bz);
    @(posedge clk);
    if (m_mul_left > 0) m_mul_left--;
    if (m_mem_wait && bus.mem_ack) m_mem_wait = 1'b0;
    if (is) begin
      if (bus.dec_mul && MC > 1) m_mul_left = MC - 1;
      else if (bus.dec_ldst)     m_mem_wait = 1'b1;
    end
    if (bus.wb_valid) m_pend[int'(bus.wb_rd)] = 1'b0;
    if (is && bus.dec_writeback && int'(bus.dec_rd) != 0) m_pend[int'(bus.dec_rd)] = 1'b1;
    #1;
  endtask

  task automatic drv(string tag, bit exe, bit ua, bit ub, bit wbk,
                     int ra, int rb, int rd, bit mul, bit ldst,
                     bit redir, bit ack, bit wbv, int wbrd);
    bus.dec_execute   = exe;
    bus.dec_uses_ra   = ua;
    bus.dec_uses_rb   = ub;
    bus.dec_writeback = wbk;
    bus.dec_ra        = RB'(ra);
    bus.dec_rb        = RB'(rb);
    bus.dec_rd        = RB'(rd);
    bus.dec_mul       = mul;
    bus.dec_ldst      = ldst;
    bus.ex_redirect   = redir;
    bus.mem_ack       = ack;
    bus.wb_valid      = wbv;
    bus.wb_rd         = RB'(wbrd);
    cyc(tag);
  endtask

  initial begin
    model_reset();
    // Reset with active-looking inputs: every output must stay low.
    bus.dec_execute = 1'b1; bus.dec_uses_ra = 1'b0; bus.dec_uses_rb = 1'b0;
    bus.dec_writeback = 1'b0; bus.dec_ra = '0; bus.dec_rb = '0; bus.dec_rd = '0;
    bus.dec_mul = 1'b0; bus.dec_ldst = 1'b0; bus.ex_redirect = 1'b1;
    bus.mem_ack = 1'b0; bus.wb_valid = 1'b0; bus.wb_rd = '0;
    #3;
    chk("rst0.flush", bus.flush, 1'b0);
    chk("rst0.stall", bus.stall, 1'b0);
    chk("rst0.issue", bus.issue, 1'b0);
    chk("rst0.busy",  bus.busy,  1'b0);
    @(posedge clk); #1;
    rst = 1'b0;

    // RAW on r3
    drv("add_r3",  1,0,0,1, 0,0,3, 0,0, 0,0, 0,0);
    drv("raw_a",   1,1,0,1, 3,0,6, 0,0, 0,0, 0,0);
    drv("raw_b",   1,1,0,1, 3,0,6, 0,0, 0,0, 0,0);
    drv("raw_wb",  1,1,0,1, 3,0,6, 0,0, 0,0, 1,3);
    drv("raw_aft", 1,1,0,1, 3,0,6, 0,0, 0,0, 0,0);
    drv("raw_wb6", 1,1,0,1, 3,0,6, 0,0, 0,0, 1,6);
    drv("raw_fin", 1,1,0,0, 3,0,0, 0,0, 0,0, 0,0);
    drv("idle",    0,0,0,0, 0,0,0, 0,0, 0,0, 1,6);

    // MUL r2: two stall cycles then RUN
    drv("mul_r2",  1,0,0,1, 0,0,2, 1,0, 0,0, 0,0);
    drv("mul_w1",  1,0,0,0, 7,0,0, 0,0, 0,1, 0,0);
    drv("mul_w2",  1,0,0,0, 7,0,0, 0,0, 0,0, 0,0);
    drv("mul_run", 1,0,0,0, 7,0,0, 0,0, 0,0, 1,2);

    // Load r5, ack four cycles later
    drv("ld_r5",   1,0,0,1, 0,0,5, 0,1, 0,0, 0,0);
    drv("ld_w1",   1,0,0,0, 7,0,0, 0,0, 0,0, 0,0);
    drv("ld_w2",   1,0,0,0, 7,0,0, 0,0, 0,0, 0,0);
    drv("ld_w3",   0,0,0,0, 7,0,0, 0,0, 0,0, 0,0);
    drv("ld_ack",  1,0,0,0, 7,0,0, 0,0, 0,1, 0,0);
    drv("ld_run",  1,1,0,0, 7,0,0, 0,0, 0,0, 0,0);
    drv("ld_dep",  1,1,0,0, 5,0,0, 0,0, 0,0, 0,0);
    drv("ld_wb5",  1,1,0,0, 5,0,0, 0,0, 0,0, 1,5);
    drv("ld_dep2", 1,1,0,0, 5,0,0, 0,0, 0,0, 0,0);

    // Redirect while a dependent is stalled in MEMWAIT
    drv("ld_r8",   1,0,0,1, 0,0,8, 0,1, 0,0, 0,0);
    drv("dep_r8",  1,0,1,0, 0,8,0, 0,0, 0,0, 0,0);
    drv("redir",   1,0,1,0, 0,8,0, 0,0, 1,0, 0,0);
    drv("post_rd", 1,0,0,0, 0,0,0, 0,0, 0,0, 0,0);
    drv("rd_ack",  1,0,0,0, 0,0,0, 0,0, 0,1, 0,0);
    drv("rd_run",  1,0,0,0, 0,0,0, 0,0, 0,0, 1,8);

    // R0 never pending; same-cycle set/clear of r4 keeps r4 set
    drv("wr_r0",   1,0,0,1, 0,0,0, 0,0, 0,0, 0,0);
    drv("rd_r0",   1,1,1,1, 0,0,0, 0,0, 0,0, 0,0);
    drv("col_r4",  1,0,0,1, 0,0,4, 0,0, 0,0, 1,4);
    drv("use_r4",  1,1,0,0, 4,0,0, 0,0, 0,0, 0,0);
    drv("clr_r4",  0,0,0,0, 0,0,0, 0,0, 0,0, 1,4);
    drv("use_r4b", 1,1,0,0, 4,0,0, 0,0, 0,0, 0,0);

    // Reset asserted in the middle of MULWAIT
    drv("mul_r9",  1,0,0,1, 0,0,9, 1,0, 0,0, 0,0);
    bus.dec_execute = 1'b1; bus.ex_redirect = 1'b1; bus.dec_mul = 1'b0;
    bus.dec_writeback = 1'b0;
    #1; rst = 1'b1; #1;
    chk("rstm.flush", bus.flush, 1'b0);
    chk("rstm.stall", bus.stall, 1'b0);
    chk("rstm.issue", bus.issue, 1'b0);
    chk("rstm.busy",  bus.busy,  1'b0);
    model_reset();
    @(posedge clk); #1;
    rst = 1'b0;
    drv("add_r1",  1,0,0,1, 0,0,1, 0,0, 0,0, 0,0);
    drv("use_r9",  1,1,0,0, 9,0,0, 0,0, 0,0, 0,0);

    // Random traffic
    for (int k = 0; k < 400; k++) begin
      drv("rnd",
          $urandom_range(0,3) != 0, $urandom_range(0,1) == 1,
          $urandom_range(0,1) == 1, $urandom_range(0,1) == 1,
          int'($urandom_range(0,7)), int'($urandom_range(0,7)),
          int'($urandom_range(0,7)),
          $urandom_range(0,5) == 0, $urandom_range(0,5) == 0,
          $urandom_range(0,9) == 0, $urandom_range(0,3) == 0,
          $urandom_range(0,2) == 0, int'($urandom_range(0,7)));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
